// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared constants, slot states and grant helper for the ECC unit share arbiter
package ecc_pkg;

  localparam int OPW = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } slot_state_t;

  localparam int REQ_ADD = 0;
  localparam int REQ_INV = 1;

  // On a tie the requester that did not go last wins; otherwise the only pending one.
  function automatic logic rr_pick(input logic [1:0] pend, input logic last);
    if (&pend) return ~last;
    return pend[1];
  endfunction

endpackage

// File: rtl/ecc_unit_share_arb_if.sv
// rtl/ecc_unit_share_arb_if.sv - requester and arithmetic-unit signals of the ECC unit share arbiter
interface ecc_unit_share_arb_if #(parameter int OPW = ecc_pkg::OPW);

  logic [1:0]       rq_mul_en;
  logic [OPW-1:0]   rq_mul_a0, rq_mul_a1, rq_mul_b0, rq_mul_b1;
  logic [1:0]       rq_mul_as, rq_mul_bs;
  logic [1:0]       rq_mul_done;
  logic [1:0]       rq_mod_en;
  logic [2*OPW-1:0] rq_mod_x0, rq_mod_x1;
  logic [1:0]       rq_mod_xs;
  logic [1:0]       rq_mod_done;
  logic             mul_en;
  logic [OPW-1:0]   mul_a, mul_b;
  logic             mul_as, mul_bs;
  logic             mul_done;
  logic             mod_en;
  logic [2*OPW-1:0] mod_x;
  logic             mod_xs;
  logic             mod_done;
  logic             mul_busy, mod_busy;
  logic             proto_err;

  modport slave (
    input  rq_mul_en, rq_mul_a0, rq_mul_a1, rq_mul_b0, rq_mul_b1, rq_mul_as, rq_mul_bs,
    input  rq_mod_en, rq_mod_x0, rq_mod_x1, rq_mod_xs, mul_done, mod_done,
    output rq_mul_done, rq_mod_done, mul_en, mul_a, mul_b, mul_as, mul_bs,
    output mod_en, mod_x, mod_xs, mul_busy, mod_busy, proto_err
  );

  modport master (
    output rq_mul_en, rq_mul_a0, rq_mul_a1, rq_mul_b0, rq_mul_b1, rq_mul_as, rq_mul_bs,
    output rq_mod_en, rq_mod_x0, rq_mod_x1, rq_mod_xs, mul_done, mod_done,
    input  rq_mul_done, rq_mod_done, mul_en, mul_a, mul_b, mul_as, mul_bs,
    input  mod_en, mod_x, mod_xs, mul_busy, mod_busy, proto_err
  );

endinterface

// File: rtl/ecc_res_slot.sv
// rtl/ecc_res_slot.sv - one shared-unit slot: pending capture, round-robin grant, issue/wait FSM, done routing
module ecc_res_slot
  import ecc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_en,
  input  logic [W-1:0] req_pl0,
  input  logic [W-1:0] req_pl1,
  input  logic         unit_done,
  output logic         unit_en,
  output logic [W-1:0] unit_pl,
  output logic [1:0]   rq_done,
  output logic         busy,
  output logic         err
);

  slot_state_t  st, st_nx;
  logic [1:0]   pend, pend_nx, acc, viol, clr;
  logic [W-1:0] cap0, cap1;
  logic         owner, last, win;

  assign win  = rr_pick(pend, last);
  assign busy = (st != IDLE);

  // Accept a request unless that requester is already queued or is being served right now.
  always_comb begin
    acc  = '0;
    viol = '0;
    for (int i = 0; i < 2; i++) begin
      if (req_en[i]) begin
        if (pend[i] || (st == WAIT && owner == 1'(i))) viol[i] = 1'b1;
        else                                           acc[i]  = 1'b1;
      end
    end
  end

  // Slot FSM next state, unit drive and done routing; the winner is chosen in ISSUE.
  always_comb begin
    st_nx   = st;
    clr     = '0;
    unit_en = 1'b0;
    unit_pl = '0;
    rq_done = '0;
    case (st)
      IDLE: begin
        if (|(pend | acc)) st_nx = ISSUE;
      end
      ISSUE: begin
        unit_en  = 1'b1;
        unit_pl  = win ? cap1 : cap0;
        clr[win] = 1'b1;
        st_nx    = WAIT;
      end
      WAIT: begin
        unit_pl        = owner ? cap1 : cap0;
        rq_done[owner] = unit_done;
        if (unit_done) st_nx = (|(pend | acc)) ? ISSUE : IDLE;
      end
      default: st_nx = IDLE;
    endcase
    pend_nx = (pend & ~clr) | acc;
  end

  // State, pending bits, operand capture, owner/last pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      pend  <= '0;
      cap0  <= '0;
      cap1  <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      err   <= 1'b0;
    end else begin
      st   <= st_nx;
      pend <= pend_nx;
      if (acc[0]) cap0 <= req_pl0;
      if (acc[1]) cap1 <= req_pl1;
      if (st == ISSUE) begin
        owner <= win;
        last  <= win;
      end
      err <= err | (|viol);
    end
  end

endmodule

// File: rtl/ecc_unit_share_arb.sv
// rtl/ecc_unit_share_arb.sv - shares MUL64 and MOD between the add/double and inverse engines
module ecc_unit_share_arb
  import ecc_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  ecc_unit_share_arb_if.slave bus
);

  localparam int MUL_W = 2*OPW + 2;
  localparam int MOD_W = 2*OPW + 1;

  logic [MUL_W-1:0] mul_pl;
  logic [MOD_W-1:0] mod_pl;
  logic             mul_err, mod_err;

  ecc_res_slot #(.W(MUL_W)) u_mul_slot (
    .clk       (clk),
    .rst       (rst),
    .req_en    (bus.rq_mul_en),
    .req_pl0   ({bus.rq_mul_as[REQ_ADD], bus.rq_mul_bs[REQ_ADD], bus.rq_mul_a0, bus.rq_mul_b0}),
    .req_pl1   ({bus.rq_mul_as[REQ_INV], bus.rq_mul_bs[REQ_INV], bus.rq_mul_a1, bus.rq_mul_b1}),
    .unit_done (bus.mul_done),
    .unit_en   (bus.mul_en),
    .unit_pl   (mul_pl),
    .rq_done   (bus.rq_mul_done),
    .busy      (bus.mul_busy),
    .err       (mul_err)
  );

  ecc_res_slot #(.W(MOD_W)) u_mod_slot (
    .clk       (clk),
    .rst       (rst),
    .req_en    (bus.rq_mod_en),
    .req_pl0   ({bus.rq_mod_xs[REQ_ADD], bus.rq_mod_x0}),
    .req_pl1   ({bus.rq_mod_xs[REQ_INV], bus.rq_mod_x1}),
    .unit_done (bus.mod_done),
    .unit_en   (bus.mod_en),
    .unit_pl   (mod_pl),
    .rq_done   (bus.rq_mod_done),
    .busy      (bus.mod_busy),
    .err       (mod_err)
  );

  assign {bus.mul_as, bus.mul_bs, bus.mul_a, bus.mul_b} = mul_pl;
  assign {bus.mod_xs, bus.mod_x}                        = mod_pl;
  assign bus.proto_err                                  = mul_err | mod_err;

endmodule

// File: tb/tb_ecc_unit_share_arb.sv
// tb/tb_ecc_unit_share_arb.sv - directed and randomized checks of ecc_unit_share_arb against a transaction model
module tb_ecc_unit_share_arb;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_unit_share_arb_if #(.OPW(OPW)) bus();

  ecc_unit_share_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: per slot a set of waiting requests with their operands, the requester being
  // served (-1 when free), whether the one-cycle issue is in progress, and the operands
  // handed to the unit at grant time.
  bit           m_pend[2][2];
  logic [129:0] m_data[2][2];
  int           m_owner[2];
  bit           m_issuing[2];
  bit           m_last[2];
  logic [129:0] m_cur[2];
  bit           m_err;

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[s][i] = 1'b0;
        m_data[s][i] = '0;
      end
      m_owner[s]   = -1;
      m_issuing[s] = 1'b0;
      m_last[s]    = 1'b1;
      m_cur[s]     = '0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [129:0] req_payload(int s, int i);
    if (s == 0)
      return (i == 0) ? {bus.rq_mul_as[0], bus.rq_mul_bs[0], bus.rq_mul_a0, bus.rq_mul_b0}
                      : {bus.rq_mul_as[1], bus.rq_mul_bs[1], bus.rq_mul_a1, bus.rq_mul_b1};
    return (i == 0) ? {1'b0, bus.rq_mod_xs[0], bus.rq_mod_x0}
                    : {1'b0, bus.rq_mod_xs[1], bus.rq_mod_x1};
  endfunction

  task automatic grant(input int s);
    int w;
    if (m_pend[s][0] && m_pend[s][1]) w = m_last[s] ? 0 : 1;
    else                              w = m_pend[s][1] ? 1 : 0;
    m_pend[s][w] = 1'b0;
    m_last[s]    = (w == 1);
    m_owner[s]   = w;
    m_issuing[s] = 1'b1;
    m_cur[s]     = m_data[s][w];
  endtask

  task automatic model_step();
    logic [1:0] req;
    logic       ud;
    if (rst) begin
      model_reset();
      return;
    end
    for (int s = 0; s < 2; s++) begin
      req = (s == 0) ? bus.rq_mul_en : bus.rq_mod_en;
      ud  = (s == 0) ? bus.mul_done : bus.mod_done;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (m_pend[s][i] || m_owner[s] == i) m_err = 1'b1;
          else begin
            m_pend[s][i] = 1'b1;
            m_data[s][i] = req_payload(s, i);
          end
        end
      end
      if (m_owner[s] < 0) begin
        if (m_pend[s][0] || m_pend[s][1]) grant(s);
      end else if (m_issuing[s]) begin
        m_issuing[s] = 1'b0;
      end else if (ud) begin
        m_owner[s] = -1;
        m_cur[s]   = '0;
        if (m_pend[s][0] || m_pend[s][1]) grant(s);
      end
    end
  endtask

  task automatic compare_all();
    logic [1:0] ed0, ed1;
    ed0 = (m_owner[0] >= 0 && !m_issuing[0] && bus.mul_done) ? ((m_owner[0] == 1) ? 2'b10 : 2'b01) : 2'b00;
    ed1 = (m_owner[1] >= 0 && !m_issuing[1] && bus.mod_done) ? ((m_owner[1] == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("mul_en",      130'(bus.mul_en), 130'(m_issuing[0]));
    check("mul_ops",     {bus.mul_as, bus.mul_bs, bus.mul_a, bus.mul_b}, m_cur[0]);
    check("rq_mul_done", 130'(bus.rq_mul_done), 130'(ed0));
    check("mul_busy",    130'(bus.mul_busy), 130'(m_owner[0] >= 0));
    check("mod_en",      130'(bus.mod_en), 130'(m_issuing[1]));
    check("mod_ops",     {1'b0, bus.mod_xs, bus.mod_x}, m_cur[1]);
    check("rq_mod_done", 130'(bus.rq_mod_done), 130'(ed1));
    check("mod_busy",    130'(bus.mod_busy), 130'(m_owner[1] >= 0));
    check("proto_err",   130'(bus.proto_err), 130'(m_err));
  endtask

  // Inputs are set at the falling edge; compare, clock, update model, then drop pulses.
  task automatic tick();
    #1;
    compare_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst           = 1'b0;
    bus.rq_mul_en = '0;
    bus.rq_mod_en = '0;
    bus.mul_done  = 1'b0;
    bus.mod_done  = 1'b0;
  endtask

  int n_issue;
  int who;

  initial begin
    rst = 1'b1;
    bus.rq_mul_en = '0; bus.rq_mul_a0 = '0; bus.rq_mul_a1 = '0; bus.rq_mul_b0 = '0; bus.rq_mul_b1 = '0;
    bus.rq_mul_as = '0; bus.rq_mul_bs = '0;
    bus.rq_mod_en = '0; bus.rq_mod_x0 = '0; bus.rq_mod_x1 = '0; bus.rq_mod_xs = '0;
    bus.mul_done = 1'b0; bus.mod_done = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mul_en",    130'(bus.mul_en), 130'(0));
    check("rst_mod_x",     130'(bus.mod_x), 130'(0));
    check("rst_proto_err", 130'(bus.proto_err), 130'(0));
    tick();

    // Single multiply from requester 0.
    bus.rq_mul_en = 2'b01; bus.rq_mul_a0 = 64'd3; bus.rq_mul_b0 = 64'd5; bus.rq_mul_as = 2'b01;
    tick();
    #1;
    check("single_en", 130'(bus.mul_en), 130'(1));
    check("single_a",  130'(bus.mul_a), 130'(3));
    check("single_b",  130'(bus.mul_b), 130'(5));
    check("single_as", 130'(bus.mul_as), 130'(1));
    for (int k = 0; k < 4; k++) tick();
    bus.mul_done = 1'b1;
    #1;
    check("single_done", 130'(bus.rq_mul_done), 130'(2'b01));
    tick();

    // Contention on MOD: requester 0 first, requester 1 the cycle after the done.
    bus.rq_mod_en = 2'b11; bus.rq_mod_x0 = 128'd100; bus.rq_mod_x1 = 128'd200;
    tick();
    #1;
    check("cont_x0", 130'(bus.mod_x), 130'(100));
    tick();
    bus.mod_done = 1'b1;
    #1;
    check("cont_done0", 130'(bus.rq_mod_done), 130'(2'b01));
    tick();
    #1;
    check("cont_en1", 130'(bus.mod_en), 130'(1));
    check("cont_x1",  130'(bus.mod_x), 130'(200));
    tick();
    bus.mod_done = 1'b1;
    #1;
    check("cont_done1", 130'(bus.rq_mod_done), 130'(2'b10));
    tick();

    // Fairness: three ties in a row give 0,1,0,1,0,1.
    for (int r = 0; r < 3; r++) begin
      bus.rq_mod_en = 2'b11; bus.rq_mod_x0 = 128'(10 + r); bus.rq_mod_x1 = 128'(20 + r);
      tick();
      for (int k = 0; k < 2; k++) begin
        #1;
        check("fair_en", 130'(bus.mod_en), 130'(1));
        who = (bus.mod_x == bus.rq_mod_x0) ? 0 : 1;
        check("fair_order", 130'(who), 130'(k));
        tick();
        bus.mod_done = 1'b1;
        tick();
      end
    end

    // Concurrency: MUL for requester 0, MOD for requester 1.
    bus.rq_mul_en = 2'b01; bus.rq_mul_a0 = 64'd7;
    bus.rq_mod_en = 2'b10; bus.rq_mod_x1 = 128'd9;
    tick();
    tick();
    #1;
    check("conc_mul_busy", 130'(bus.mul_busy), 130'(1));
    check("conc_mod_busy", 130'(bus.mod_busy), 130'(1));
    bus.mul_done = 1'b1; bus.mod_done = 1'b1;
    #1;
    check("conc_mul_done", 130'(bus.rq_mul_done), 130'(2'b01));
    check("conc_mod_done", 130'(bus.rq_mod_done), 130'(2'b10));
    tick();

    // Violation: requester 1 requests twice while still pending.
    bus.rq_mul_en = 2'b01; bus.rq_mul_a0 = 64'd1;
    tick();
    tick();
    bus.rq_mul_en = 2'b10; bus.rq_mul_a1 = 64'd11;
    tick();
    bus.rq_mul_en = 2'b10; bus.rq_mul_a1 = 64'd12;
    tick();
    #1;
    check("viol_err", 130'(bus.proto_err), 130'(1));
    n_issue = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.mul_en) begin
        n_issue++;
        check("viol_a1", 130'(bus.mul_a), 130'(11));
      end
      bus.mul_done = bus.mul_busy && !bus.mul_en;
      tick();
    end
    check("viol_issues", 130'(n_issue), 130'(1));

    // Reset in WAIT followed by a stale done.
    bus.rq_mul_en = 2'b01; bus.rq_mul_a0 = 64'd42;
    tick();
    tick();
    #1;
    check("rw_busy", 130'(bus.mul_busy), 130'(1));
    rst = 1'b1;
    tick();
    bus.mul_done = 1'b1;
    #1;
    check("rw_done", 130'(bus.rq_mul_done), 130'(0));
    check("rw_en",   130'(bus.mul_en), 130'(0));
    check("rw_a",    130'(bus.mul_a), 130'(0));
    check("rw_busy0", 130'(bus.mul_busy), 130'(0));
    check("rw_err",  130'(bus.proto_err), 130'(0));
    tick();

    // Randomized traffic, including stale dones, violations and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 249) == 0);
      bus.rq_mul_en = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0};
      bus.rq_mod_en = {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0};
      bus.rq_mul_a0 = {$urandom, $urandom}; bus.rq_mul_a1 = {$urandom, $urandom};
      bus.rq_mul_b0 = {$urandom, $urandom}; bus.rq_mul_b1 = {$urandom, $urandom};
      bus.rq_mul_as = 2'($urandom);         bus.rq_mul_bs = 2'($urandom);
      bus.rq_mod_x0 = {$urandom, $urandom, $urandom, $urandom};
      bus.rq_mod_x1 = {$urandom, $urandom, $urandom, $urandom};
      bus.rq_mod_xs = 2'($urandom);
      bus.mul_done  = ($urandom_range(0, 2) == 0);
      bus.mod_done  = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_unit_share_arb.md
# ecc_unit_share_arb

Round-robin arbiter and sequencer that shares the single MUL64 multiplier and the single MOD reducer between two requesters: requester 0, the point add/double engine, and requester 1, the modular-inverse engine. It sits inside the ALU between the requesters and the arithmetic units. Each requester keeps its own enable/done handshake, so neither needs to know the other exists. It replaces routing that depends on the add/double engine's state.

## Interface
- OPW, 64: multiplier operand magnitude width; multiplier result and MOD input are 2*OPW, MOD result is OPW.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rq_mul_en[1:0]  in  2  per-requester multiply request pulse (1 cycle)
- rq_mul_a0/a1, rq_mul_b0/b1  in  OPW each  operand magnitudes per requester
- rq_mul_as[1:0], rq_mul_bs[1:0]  in  2 each  operand sign bits per requester
- rq_mul_done[1:0]  out  2  multiply done, routed to owner only
- rq_mod_en[1:0]  in  2  per-requester reduce request pulse
- rq_mod_x0/x1  in  2*OPW each; rq_mod_xs[1:0]  in  2  reduce input and sign
- rq_mod_done[1:0]  out  2  reduce done, routed to owner only
- mul_en  out  1; mul_a, mul_b  out  OPW; mul_as, mul_bs  out  1  to MUL64
- mul_done  in  1  from MUL64; mul_result is fanned out to both requesters directly, not through this block
- mod_en  out  1; mod_x  out  2*OPW; mod_xs  out  1  to MOD
- mod_done  in  1  from MOD; mod_result is fanned out directly
- mul_busy, mod_busy  out  1 each  unit in ISSUE or WAIT
- proto_err  out  1  sticky; set on a protocol violation, cleared only by rst

## Operation
- Two independent, identical resource slots: MUL and MOD.
- Per slot, per requester: a pending bit plus a captured operand register.
- A request pulse sets the pending bit and captures the operands in the same edge.
- Slot FSM states:
  - IDLE: if any pending bit is set, go to ISSUE.
  - ISSUE: drive unit enable high for exactly one cycle, then go to WAIT.
  - WAIT: hold until the unit's done input is high.
- Operands driven to the unit come from the owner's captured register. They are held stable from ISSUE through the done cycle and are zero in IDLE.
- Grant: round-robin. Each slot keeps a last-owner pointer; when both requesters are pending, the one that is not the last owner wins. The pointer resets to 1, so requester 0 wins the first tie.
- The grant clears the winner's pending bit and records the owner.
- Done routing: rq_*_done[owner] = unit done AND (state == WAIT), combinational. The non-owner's done is always 0.
- A unit done seen in IDLE or ISSUE is ignored. This covers a stale done after a reset mid-operation.
- On the done cycle:
  - if any pending bit is set, including a request arriving in that same cycle, go directly to ISSUE;
  - otherwise go to IDLE.
- Protocol violations set proto_err and drop the request:
  - a request from a requester whose pending bit is already set;
  - a request from a requester that currently owns that slot.
- rst:
  - all slots go to IDLE;
  - pending bits, captured operands, owners and proto_err clear to 0;
  - last-owner pointer goes to 1.

## Timing
- Reset values: all *_en, *_done, *_busy and proto_err are 0; all operand outputs are 0.
- Uncontended request in cycle N (slot IDLE): ISSUE in N+1 (unit enable high), WAIT from N+2.
- Owner's done is high in the same cycle as the unit done. Added overhead is 1 cycle of request-to-enable latency.
- Back-to-back: with a pending request at the done cycle D, the next enable pulse is at D+1.
- A request in the same cycle as rst is lost.
- MUL and MOD slots may both be in WAIT with different owners at the same time.

## Structure
- Package ecc_pkg holds:
  - OPW default;
  - slot state encoding IDLE=0, ISSUE=1, WAIT=2;
  - requester indices REQ_ADD=0, REQ_INV=1.
- One sub-module, ecc_res_slot, parameterized by operand payload width: pending bits, capture registers, round-robin grant, FSM, done routing.
  - Instance for MUL uses a payload of 2*OPW+2.
  - Instance for MOD uses a payload of 2*OPW+1.
- Top level only splits and concatenates payloads and ORs the two slots' error flags into proto_err.

## Test plan
- Single multiply: rq_mul_en[0] with a0=3, b0=5, as=1. Required: mul_en pulses one cycle later with mul_a=3, mul_b=5, mul_as=1. A mul_done 4 cycles later gives rq_mul_done=2'b01 in that same cycle.
- Contention: rq_mod_en=2'b11 in one cycle with x0=100, x1=200. Required:
  - requester 0 is served first, mod_x=100;
  - requester 1 is issued at D+1 with mod_x=200;
  - each done reaches only its owner.
- Fairness: repeat the tie three times. Required grant order is 0,1,0,1,0,1.
- Concurrency: MUL owned by requester 0 and MOD by requester 1 at once. Required: both busy flags high, and each done is routed correctly with no cross-talk.
- Violation: a second rq_mul_en[1] while requester 1 is still pending. Required: proto_err=1 on the next cycle, and only one issue for requester 1.
- Reset mid-WAIT: assert rst during WAIT, then inject a stale mul_done. Required: all outputs 0 and no rq_mul_done pulse.
